alu_exec_seq: RTL and testbench

//  Execution end of the 4-bit ALUcontrol interface: consumes ALUcontrol codes

---
 rtl/alu_exec_seq.sv | 137 +++++++++++++
 tb/tb_alu_exec_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_seq.sv
// Execution end of the ALUcontrol path: one-cycle logic/add/sub,
// serial one-bit-per-cycle SLL/SRL, valid/ready on both sides.
module alu_exec_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SLL = 4'b0011;
  localparam logic [3:0] C_SRL = 4'b0100;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_XOR = 4'b1001;

  logic [1:0]         state;
  logic               live;
  logic [XLEN-1:0]    sreg;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_left;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    calc;
  logic               calc_ill;
  logic               is_shift;
  logic               go_serial;
  logic               accept;
  logic [XLEN-1:0]    shifted;

  assign shamt     = op_b[SHAMT_W-1:0];
  assign in_ready  = live && (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign go_serial = is_shift && (shamt > SHAMT_W'(1));
  assign shifted   = dir_left ? (sreg << 1) : (sreg >> 1);

  // Shifts of 0 or 1 finish in the accept cycle like the single-cycle ops.
  always_comb begin
    calc     = '0;
    calc_ill = 1'b0;
    is_shift = 1'b0;
    unique case (1'b1)
      (alu_ctrl == C_AND): calc = op_a & op_b;
      (alu_ctrl == C_OR):  calc = op_a | op_b;
      (alu_ctrl == C_XOR): calc = op_a ^ op_b;
      (alu_ctrl == C_ADD): calc = op_a + op_b;
      (alu_ctrl == C_SUB): calc = op_a - op_b;
      (alu_ctrl == C_SLL): begin
        is_shift = 1'b1;
        calc     = (shamt == '0) ? op_a : (op_a << 1);
      end
      (alu_ctrl == C_SRL): begin
        is_shift = 1'b1;
        calc     = (shamt == '0) ? op_a : (op_a >> 1);
      end
      default: calc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sreg      <= '0;
      cnt       <= '0;
      dir_left  <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            illegal  <= calc_ill;
            dir_left <= (alu_ctrl == C_SLL);
            if (go_serial) begin
              // First bit is shifted on the accept edge itself.
              sreg  <= calc;
              cnt   <= shamt - SHAMT_W'(1);
              state <= S_SHIFT;
            end else begin
              result    <= calc;
              zero      <= (calc == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          sreg <= shifted;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result    <= shifted;
            zero      <= (shifted == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: latency, result, flags,
// backpressure and reset abort.
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_seq #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_ctrl(alu_ctrl),
    .op_a(op_a),
    .op_b(op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .illegal(illegal)
  );

  task automatic send(input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b);
    int k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready got %b want 1", in_ready);
    end
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, zero, illegal} !== 4'b0000 || result !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state got rdy=%b ov=%b z=%b il=%b r=%h want all 0",
               in_ready, out_valid, zero, illegal, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    send(4'b0010, 32'h5, 32'h3);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'h8 || zero !== 1'b0 || lat != 1) begin
      n_bad++;
      $display("FAIL add got r=%h z=%b lat=%0d want 00000008 0 1", result, zero, lat);
    end
    pop();
  endtask

  task automatic test_sub();
    int lat;
    send(4'b0110, 32'h1234_5678, 32'h1234_5678);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'h0 || zero !== 1'b1 || lat != 1) begin
      n_bad++;
      $display("FAIL sub_eq got r=%h z=%b lat=%0d want 00000000 1 1", result, zero, lat);
    end
    pop();
    send(4'b0110, 32'h0, 32'h1);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_wrap got r=%h z=%b want ffffffff 0", result, zero);
    end
    pop();
  endtask

  task automatic test_sll();
    int lat;
    send(4'b0011, 32'h1, 32'h1F);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'h8000_0000 || zero !== 1'b0 || lat != 31) begin
      n_bad++;
      $display("FAIL sll31 got r=%h z=%b lat=%0d want 80000000 0 31", result, zero, lat);
    end
    pop();
    send(4'b0011, 32'h1, 32'h20);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'h1 || lat != 1) begin
      n_bad++;
      $display("FAIL sll0 got r=%h lat=%0d want 00000001 1", result, lat);
    end
    pop();
  endtask

  task automatic test_srl();
    int lat;
    send(4'b0100, 32'h8000_0000, 32'h4);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL srl_busy got in_ready=%b want 0", in_ready);
    end
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'h1; op_b = 32'h1;
    wait_out(lat);
    n_cmp++;
    if (result !== 32'h0800_0000 || lat != 4 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL srl4 got r=%h lat=%0d rdy=%b want 08000000 4 0",
               result, lat, in_ready);
    end
    in_valid = 1'b0;
    pop();
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL srl_ignored got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    int lat;
    send(4'b0101, 32'h7, 32'h9);
    wait_out(lat);
    n_cmp++;
    if (illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || lat != 1) begin
      n_bad++;
      $display("FAIL illegal got il=%b r=%h z=%b lat=%0d want 1 00000000 1 1",
               illegal, result, zero, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 ||
          in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall%0d got ov=%b il=%b r=%h rdy=%b want 1 1 0 0",
                 i, out_valid, illegal, result, in_ready);
      end
    end
    pop();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(4'b0010, 32'hFFFF_FFFF, 32'h1);
    wait_out(lat);
    n_cmp++;
    if (illegal !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL add_wrap got il=%b r=%h z=%b want 0 00000000 1",
               illegal, result, zero);
    end
    pop();
    send(4'b0001, 32'h0000_00A0, 32'h0000_000B);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'h0000_00AB || lat != 1) begin
      n_bad++;
      $display("FAIL or got r=%h lat=%0d want 000000ab 1", result, lat);
    end
    pop();
    send(4'b1001, 32'hFFFF_0000, 32'hFF00_FF00);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'h00FF_FF00 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL xor got r=%h z=%b want 00ffff00 0", result, zero);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int lat;
    send(4'b0011, 32'h1, 32'd20);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort got ov=%b r=%h rdy=%b want 0 00000000 0",
               out_valid, result, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'hF000_F000 || lat != 1 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL and got r=%h lat=%0d il=%b want f000f000 1 0",
               result, lat, illegal);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_sll();
    test_srl();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
